// File: rtl/uart_host_bridge.sv
// Host-side bus master for the UART 8-bit register bus: one chip-select strobe per access
// with programmable setup/strobe/recovery phases, plus a synchronised interrupt request.
module uart_host_bridge #(
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 3,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [2:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       busy_o,
  output logic       chip_sel_n_o,
  output logic       read_write_o,
  output logic [2:0] address_o,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  input  logic [7:0] data_i,
  input  logic       ireq_n_i,
  output logic       irq_o
);

  localparam int MAX_ST = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C  = (MAX_ST > RECOVERY_CYCLES) ? MAX_ST : RECOVERY_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  typedef struct packed {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_d;
  logic          accept, cnt_last, bus_phase, end_strobe;
  logic [1:0]    ireq_sync;

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign cnt_last    = (cnt_q == CW'(1));
  assign end_strobe  = (state_q == STROBE) && cnt_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        cnt_d   = CW'(SETUP_CYCLES);
      end
      SETUP: if (cnt_last) begin
        state_d = STROBE;
        cnt_d   = CW'(STROBE_CYCLES);
      end else cnt_d = cnt_q - CW'(1);
      STROBE: if (cnt_last) begin
        state_d = RECOVER;
        cnt_d   = CW'(RECOVERY_CYCLES);
      end else cnt_d = cnt_q - CW'(1);
      RECOVER: if (cnt_last) state_d = IDLE;
               else cnt_d = cnt_q - CW'(1);
      default: state_d = IDLE;
    endcase
  end

  // Bus pins are registered from the next-state view so the pins change on the phase boundary.
  always_comb begin
    req_d = req_q;
    if (accept) req_d = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i};
  end
  assign bus_phase = (state_d == SETUP) || (state_d == STROBE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      chip_sel_n_o <= 1'b1;
      read_write_o <= 1'b1;
      data_oe_o    <= 1'b0;
      address_o    <= '0;
      data_o       <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      chip_sel_n_o <= (state_d != STROBE);
      read_write_o <= bus_phase ? ~req_d.write : 1'b1;
      data_oe_o    <= bus_phase & req_d.write;
      address_o    <= req_d.addr;
      data_o       <= req_d.wdata;
      rsp_valid_o  <= end_strobe;
      if (end_strobe) rsp_rdata_o <= req_q.write ? 8'h00 : data_i;
    end
  end

  // Two-flop synchroniser; flops idle at the deasserted (high) level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ireq_sync <= 2'b11;
    else       ireq_sync <= {ireq_sync[0], ireq_n_i};
  end
  assign irq_o = ~ireq_sync[1];

endmodule
